// File: rtl/incrementa_n_pkg.sv
// +----------------------------------------------------------------------------+
// | incrementa_n_pkg : FSM states, step-mode codes and widths for incrementa_n |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package incrementa_n_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_PASS = 2'b00;
  localparam mode_t MODE_INC1 = 2'b01;
  localparam mode_t MODE_DEC1 = 2'b10;
  localparam mode_t MODE_INC2 = 2'b11;

  localparam int STEPS_W = 4;

endpackage : incrementa_n_pkg

`default_nettype wire

// File: rtl/incrementa_n_inc_step.sv
// +----------------------------------------------------------------------------+
// | inc_step : one combinational step of the accumulator (pass/+1/-1/+2)       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module inc_step
  import incrementa_n_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic [WIDTH-1:0] acc_i,
  input  mode_t            mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             cy_o
);

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_ovf;
  logic             w_unf;
  logic [WIDTH-1:0] w_ovf_val;
  logic [WIDTH-1:0] w_unf_val;

  assign w_addend = (mode_i == MODE_INC2) ? WIDTH'(2) : WIDTH'(1);
  assign w_sum    = {1'b0, acc_i} + {1'b0, w_addend};
  assign w_diff   = {1'b0, acc_i} - (WIDTH+1)'(1);
  assign w_ovf    = w_sum[WIDTH];
  assign w_unf    = w_diff[WIDTH];

  // Value taken when the step leaves the representable range.
  generate
    if (SAT) begin : g_sat
      assign w_ovf_val = '1;
      assign w_unf_val = '0;
    end else begin : g_wrap
      assign w_ovf_val = w_sum[WIDTH-1:0];
      assign w_unf_val = w_diff[WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    next_o = acc_i;
    cy_o   = 1'b0;
    case (mode_i)
      MODE_INC1, MODE_INC2: begin
        next_o = w_ovf ? w_ovf_val : w_sum[WIDTH-1:0];
        cy_o   = w_ovf;
      end
      MODE_DEC1: begin
        next_o = w_unf ? w_unf_val : w_diff[WIDTH-1:0];
        cy_o   = w_unf;
      end
      default: begin
        next_o = acc_i;
        cy_o   = 1'b0;
      end
    endcase
  end

endmodule : inc_step

`default_nettype wire

// File: rtl/incrementa_n.sv
// +----------------------------------------------------------------------------+
// | incrementa_n : captures an operand (+carry-in) then applies N step ops     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module incrementa_n
  import incrementa_n_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               flag,
  input  logic [1:0]         select,
  input  logic               Ci,
  input  logic [STEPS_W-1:0] steps,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   O,
  output logic               Co
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [STEPS_W-1:0]   cnt_q, cnt_d;
  mode_t                mode_q, mode_d;
  logic                 co_int_q, co_int_d;
  logic [WIDTH-1:0]     o_q, o_d;
  logic                 co_q, co_d;
  logic                 done_q, done_d;

  logic                 w_accept;
  logic [WIDTH-1:0]     w_operand;
  logic [WIDTH:0]       w_cap;
  logic [WIDTH-1:0]     w_step_val;
  logic                 w_step_cy;

  // The done cycle itself still rejects start; the next idle cycle accepts it.
  assign w_accept  = (state_q == IDLE) && start && !done_q;
  assign w_operand = flag ? B : A;
  assign w_cap     = {1'b0, w_operand} + {{WIDTH{1'b0}}, Ci};

  inc_step #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_step (
    .acc_i  (acc_q),
    .mode_i (mode_q),
    .next_o (w_step_val),
    .cy_o   (w_step_cy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_PASS;
      co_int_q <= 1'b0;
      o_q      <= '0;
      co_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      co_int_q <= co_int_d;
      o_q      <= o_d;
      co_q     <= co_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          state_d = (steps == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (cnt_q == STEPS_W'(1)) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    co_int_d = co_int_q;
    o_d      = o_q;
    co_d     = co_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          acc_d    = w_cap[WIDTH-1:0];
          mode_d   = select;
          cnt_d    = steps;
          co_int_d = w_cap[WIDTH];
        end
      end
      RUN: begin
        acc_d    = w_step_val;
        cnt_d    = cnt_q - STEPS_W'(1);
        co_int_d = co_int_q | w_step_cy;
      end
      FIN: begin
        o_d    = acc_q;
        co_d   = co_int_q;
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    O    = o_q;
    Co   = co_q;
  end

endmodule : incrementa_n

`default_nettype wire

// File: tb/tb_incrementa_n.sv
// +----------------------------------------------------------------------------+
// | tb_incrementa_n : directed vectors against wrapping and saturating copies  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_incrementa_n;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] A, B;
  logic         flag;
  logic [1:0]   select;
  logic         Ci;
  logic [3:0]   steps;
  logic         start;

  logic         busy_w, done_w, Co_w;
  logic [W-1:0] O_w;
  logic         busy_s, done_s, Co_s;
  logic [W-1:0] O_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  incrementa_n #(.WIDTH(W), .SAT(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .flag(flag), .select(select),
    .Ci(Ci), .steps(steps), .start(start),
    .busy(busy_w), .done(done_w), .O(O_w), .Co(Co_w)
  );

  incrementa_n #(.WIDTH(W), .SAT(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .flag(flag), .select(select),
    .Ci(Ci), .steps(steps), .start(start),
    .busy(busy_s), .done(done_s), .O(O_s), .Co(Co_s)
  );

  typedef struct {
    logic       flag;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [1:0] sel;
    logic [3:0] steps;
    logic [7:0] o_wrap;
    logic       co_wrap;
    logic [7:0] o_sat;
    logic       co_sat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Latency counts the sampling edge as edge 1, so done shows up after edge steps+2.
  task automatic run_op(input vec_t v, input string tag);
    logic [W-1:0] o_before_w;
    logic [W-1:0] o_before_s;
    int           edges;
    bit           seen;
    bit           moved;
    bit           busy_lost;
    o_before_w = O_w;
    o_before_s = O_s;
    @(negedge clk);
    A = v.a; B = v.b; flag = v.flag; Ci = v.ci; select = v.sel; steps = v.steps;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = ~v.a; B = ~v.b; flag = ~v.flag; Ci = ~v.ci; select = ~v.sel; steps = ~v.steps;
    edges = 1; seen = 1'b0; moved = 1'b0; busy_lost = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_w) begin
        seen = 1'b1;
        break;
      end
      if (O_w !== o_before_w || O_s !== o_before_s) moved = 1'b1;
      if (!busy_w || !busy_s) busy_lost = 1'b1;
      @(posedge clk);
      edges++;
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(edges), 32'(v.steps) + 32'd2);
    check({tag, " done sat copy"}, 32'(done_s), 32'd1);
    check({tag, " O held while busy"}, 32'(moved), 32'd0);
    check({tag, " busy while running"}, 32'(busy_lost), 32'd0);
    check({tag, " O wrap"}, 32'(O_w), 32'(v.o_wrap));
    check({tag, " Co wrap"}, 32'(Co_w), 32'(v.co_wrap));
    check({tag, " O sat"}, 32'(O_s), 32'(v.o_sat));
    check({tag, " Co sat"}, 32'(Co_s), 32'(v.co_sat));
    // A start during the done cycle must be dropped.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, " start in done cycle ignored"}, 32'(busy_w), 32'd0);
    check({tag, " done single pulse"}, 32'(done_w), 32'd0);
  endtask

  initial begin
    int dones;

    //           flag  a      b      ci    sel    steps  o_wrap co_w  o_sat  co_s
    vecs[0] = '{1'b0, 8'h10, 8'h00, 1'b0, 2'b01, 4'd3,  8'h13, 1'b0, 8'h13, 1'b0};
    vecs[1] = '{1'b1, 8'h00, 8'hFE, 1'b1, 2'b11, 4'd1,  8'h01, 1'b1, 8'hFF, 1'b1};
    vecs[2] = '{1'b0, 8'h02, 8'h00, 1'b0, 2'b10, 4'd5,  8'hFD, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 8'h7F, 8'h00, 1'b1, 2'b01, 4'd0,  8'h80, 1'b0, 8'h80, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 8'h00, 1'b1, 2'b00, 4'd2,  8'h00, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{1'b0, 8'hFD, 8'h00, 1'b0, 2'b01, 4'd3,  8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{1'b1, 8'h00, 8'hFD, 1'b0, 2'b11, 4'd1,  8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{1'b0, 8'h01, 8'h00, 1'b0, 2'b10, 4'd1,  8'h00, 1'b0, 8'h00, 1'b0};
    vecs[8] = '{1'b1, 8'h20, 8'h80, 1'b0, 2'b10, 4'd15, 8'h71, 1'b0, 8'h71, 1'b0};
    vecs[9] = '{1'b0, 8'hFE, 8'h00, 1'b0, 2'b11, 4'd1,  8'h00, 1'b1, 8'hFF, 1'b1};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; flag = 1'b0;
    select = 2'b00; Ci = 1'b0; steps = '0;
    #12;
    check("reset busy", 32'(busy_w), 32'd0);
    check("reset done", 32'(done_w), 32'd0);
    check("reset O", 32'(O_w), 32'd0);
    check("reset Co", 32'(Co_w), 32'd0);
    check("reset busy sat", 32'(busy_s), 32'd0);

    // Release just after an edge so the very next edge samples start.
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Second start during RUN is dropped, not queued.
    @(negedge clk);
    A = 8'h00; flag = 1'b0; Ci = 1'b0; select = 2'b01; steps = 4'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    A = 8'h55; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_w) dones++;
    end
    check("busy protect done count", 32'(dones), 32'd1);
    check("busy protect O", 32'(O_w), 32'h04);

    // Reset mid-operation aborts with no done.
    @(negedge clk);
    A = 8'h40; flag = 1'b0; Ci = 1'b0; select = 2'b01; steps = 4'd10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort busy before reset", 32'(busy_w), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy_w), 32'd0);
    check("abort O", 32'(O_w), 32'd0);
    check("abort Co", 32'(Co_w), 32'd0);
    check("abort done", 32'(done_w), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_w) dones++;
    end
    check("abort no done", 32'(dones), 32'd0);
    run_op(vecs[0], "after abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_incrementa_n

`default_nettype wire

// File: doc/incrementa_n.md
INCREMENTA_N -- requirements
Module: incrementa_n

Interface
REQ-001 Parameter WIDTH, default 8, sets the data path width in bits (range 2 to 32).
REQ-002 Parameter SAT, default 0; 0 wraps on overflow/underflow, 1 saturates.
REQ-003 clk  input  1  Single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  Reset, asynchronous and active-low.
REQ-005 A  input  WIDTH  Operand 0.
REQ-006 B  input  WIDTH  Operand 1.
REQ-007 flag  input  1  Operand select: 0 selects A, 1 selects B.
REQ-008 select  input  2  Mode: 00 pass, 01 +1 per step, 10 -1 per step, 11 +2 per step.
REQ-009 Ci  input  1  Carry-in, added once to the operand at capture.
REQ-010 steps  input  4  Number of step iterations (0 to 15).
REQ-011 start  input  1  Request; sampled only while busy is 0.
REQ-012 busy  output  1  High from the cycle after an accepted start until done.
REQ-013 done  output  1  One-cycle pulse when the result is valid.
REQ-014 O  output  WIDTH  Result, held until the next done.
REQ-015 Co  output  1  Sticky overflow/borrow flag for the last operation.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and FIN.
REQ-017 In IDLE with start=1, one clock edge SHALL capture the following, then move to RUN, or to FIN if steps=0:
- acc <= (flag ? B : A) + Ci, truncated to WIDTH.
- mode <= select.
- cnt <= steps.
- Co_int <= carry out of the capture add.
REQ-018 Each RUN cycle SHALL apply one step to acc according to mode and decrement cnt; when cnt reaches 1 it SHALL move to FIN.
REQ-019 Mode 00 SHALL leave acc unchanged each step while still consuming the step count.
REQ-020 With SAT=0, the arithmetic SHALL wrap modulo 2^WIDTH and set Co_int on any carry (modes 01/11) or borrow (mode 10).
REQ-021 With SAT=1, acc SHALL clamp at all-ones (modes 01/11) or zero (mode 10) and set Co_int at the first clamp.
REQ-022 A mode 11 step from all-ones minus 1 with SAT=1 SHALL clamp to all-ones.
REQ-023 In FIN, the unit SHALL load O <= acc and Co <= Co_int, pulse done for exactly one cycle, and return to IDLE.
REQ-024 Latency SHALL be steps+2 clock edges from the edge that samples start to the edge that raises done.
REQ-025 busy SHALL be 1 in RUN and FIN and 0 in IDLE.
REQ-026 start while busy=1 SHALL be ignored, with no queuing.
REQ-027 start asserted in the cycle of done (FIN) SHALL be ignored; start is accepted from the following IDLE cycle.
REQ-028 O and Co SHALL change only at FIN, never while RUN is in progress.
REQ-029 Changes to A, B, flag, select, Ci or steps after capture SHALL have no effect on the operation in progress.

Reset
REQ-030 rst_n=0 SHALL immediately force the following, regardless of the clock:
- state IDLE.
- busy=0, done=0, O=0, Co=0.
- acc=0, cnt=0, mode=00.
REQ-031 Reset asserted mid-operation SHALL abort the operation, and no done SHALL be produced for it.
REQ-032 After rst_n is deasserted, the first rising edge SHALL be able to accept start.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE/RUN/FIN) and the mode constants (MODE_PASS, MODE_INC1, MODE_DEC1, MODE_INC2).
REQ-034 The step arithmetic SHALL be one sub-module, inc_step:
- combinational, parametrised by WIDTH and SAT.
- inputs: acc, mode.
- outputs: next value, carry/borrow.
REQ-035 The capture-time operand mux and Ci add SHALL reside in incrementa_n.

Verification (WIDTH=8)
REQ-036 Basic increment: A=0x10, flag=0, Ci=0, select=01, steps=3, start -> done 5 edges later, O=0x13, Co=0.
REQ-037 Wrap with Ci: B=0xFE, flag=1, Ci=1, select=11, steps=1, SAT=0 -> O=0x01, Co=1.
REQ-038 Saturating decrement: A=0x02, select=10, steps=5, SAT=1 -> O=0x00, Co=1.
REQ-039 Zero steps: A=0x7F, Ci=1, steps=0, select=01 -> done 2 edges after start, O=0x80, Co=0.
REQ-040 Busy protection: a second start with A=0x55 during RUN of the first operation (A=0x00, select=01, steps=4) -> single done, O=0x04.
REQ-041 Reset abort: rst_n low during RUN -> busy=0 and O=0 immediately, no done pulse, next start completes normally.
